// File: rtl/dl_arb_pkg.sv
// Shared types and helpers for the dl_rr_arbiter family.
// Holds the arbiter state encoding, pointer sizing and modular index arithmetic.
package dl_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/dl_rr_pick.sv
// Combinational rotating-priority picker: first unmasked request at or after base.
// Wraps modulo NUM_REQ, so non-power-of-two requester counts are handled.
module dl_rr_pick
  import dl_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int W       = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       base,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [NUM_REQ-1:0] winner,
  output logic [W-1:0]       winner_idx
);

  logic [W-1:0] cand;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    winner_idx = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = W'(wrap_add(int'(base), i, NUM_REQ));
      if (!found && req[cand] && !mask[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dl_rr_arbiter.sv
// Round-robin arbiter granting one multi-cycle resource to NUM_REQ requesters.
// Grants are registered and held until last beat, abandon, or the hold limit.
module dl_rr_arbiter
  import dl_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int W        = ptr_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [W-1:0]       gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_e         state, state_nxt;
  logic [W-1:0]       ptr, ptr_nxt;
  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [W-1:0]       idx_nxt;
  logic               timeout_nxt;

  logic               rel_last, rel_abandon, rel_force, release_now;
  logic [W-1:0]       owner_next;
  logic [W-1:0]       pick_base;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [NUM_REQ-1:0] pick_winner;
  logic [W-1:0]       pick_idx;

  // The registered gnt_idx is the owner; gnt doubles as the owner mask.
  assign rel_last    = req[gnt_idx] & last[gnt_idx];
  assign rel_abandon = ~req[gnt_idx];
  assign rel_force   = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
  assign release_now = (state == OWNED) && (rel_last || rel_abandon || rel_force);
  assign owner_next  = W'(wrap_add(int'(gnt_idx), 1, NUM_REQ));
  assign pick_base   = (state == OWNED) ? owner_next : ptr;
  assign pick_mask   = (state == OWNED) ? gnt : '0;

  dl_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .base       (pick_base),
    .mask       (pick_mask),
    .found      (pick_found),
    .winner     (pick_winner),
    .winner_idx (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = OWNED;
      OWNED:   if (release_now && !pick_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt  = pick_winner;
          idx_nxt  = pick_idx;
          hold_nxt = HW'(1);
        end
      end
      OWNED: begin
        if (release_now) begin
          ptr_nxt     = owner_next;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_nxt = rel_force && !rel_last && !rel_abandon;
          if (pick_found) begin
            gnt_nxt  = pick_winner;
            idx_nxt  = pick_idx;
            hold_nxt = HW'(1);
          end else begin
            gnt_nxt  = '0;
            idx_nxt  = '0;
            hold_nxt = '0;
          end
        end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= |gnt_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_dl_rr_arbiter.sv
// Self-checking bench for dl_rr_arbiter: directed scenarios plus random traffic,
// each cycle compared against a transaction-level ownership model.
module tb_dl_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how long, and where the search starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  dl_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int c = (start + k) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] l);
    int  win;
    bit  done_last, gone, limit;
    m_to = 1'b0;
    if (m_owner < 0) begin
      win = first_from(r, m_ptr, -1);
      if (win >= 0) begin
        m_owner = win;
        m_held  = 1;
      end
    end else begin
      done_last = r[m_owner] && l[m_owner];
      gone      = !r[m_owner];
      limit     = (MH != 0) && (m_held == MH);
      if (done_last || gone || limit) begin
        m_ptr   = (m_owner + 1) % N;
        m_to    = limit && !done_last && !gone;
        win     = first_from(r, m_ptr, m_owner);
        m_owner = win;
        m_held  = (win >= 0) ? 1 : 0;
      end else begin
        m_held = m_held + 1;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    check({tag, ".gnt"},       32'(gnt),       32'(eg));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    check({tag, ".timeout"},   32'(timeout),   32'(m_to));
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(req, last);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [N-1:0] rr_seq [4];
    rr_seq[0] = 4'b0010;
    rr_seq[1] = 4'b0100;
    rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001;

    rst  = 1'b1;
    req  = 4'b1111;
    last = 4'b0000;
    model_reset();

    // Reset with every requester active: nothing granted.
    #2;
    check("rst.gnt",       32'(gnt),       32'd0);
    check("rst.gnt_idx",   32'(gnt_idx),   32'd0);
    check("rst.gnt_valid", 32'(gnt_valid), 32'd0);
    cyc("rst_hold");
    cyc("rst_hold");
    rst = 1'b0;
    cyc("rst_release");
    check("first_grant", 32'(gnt), 32'b0001);

    // Round-robin with last on each owner's second beat.
    for (int i = 0; i < 4; i++) begin
      last = 4'b0000;
      cyc("rr_beat1");
      check("rr_hold", 32'(gnt), (i == 0) ? 32'b0001 : 32'(rr_seq[i-1]));
      last = 4'b1111;
      cyc("rr_handoff");
      check("rr_seq", 32'(gnt), 32'(rr_seq[i]));
    end
    req  = 4'b0000;
    last = 4'b0000;
    cyc("rr_drain");

    // Owner 3 abandons while requester 0 waits: hand over with wrap.
    req = 4'b1000;
    cyc("wrap_grant3");
    check("wrap_owner3", 32'(gnt), 32'b1000);
    req = 4'b0001;
    cyc("wrap_abandon");
    check("wrap_to0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    cyc("wrap_drain");

    // Forced release after MAX_HOLD cycles.
    req = 4'b0110;
    cyc("to_grant");
    check("to_owner1", 32'(gnt), 32'b0010);
    for (int i = 0; i < MH - 1; i++) cyc("to_hold");
    cyc("to_force");
    check("to_handoff", 32'(gnt), 32'b0100);
    check("to_pulse",   32'(timeout), 32'd1);
    req = 4'b0100;
    cyc("to_after");
    check("to_one_cycle", 32'(timeout), 32'd0);
    req = 4'b0000;
    cyc("to_drain");

    // Same hold length but last on the final beat: normal release.
    req = 4'b0110;
    cyc("tol_grant");
    check("tol_owner1", 32'(gnt), 32'b0010);
    for (int i = 0; i < MH - 1; i++) cyc("tol_hold");
    last = 4'b0010;
    cyc("tol_last");
    check("tol_handoff", 32'(gnt), 32'b0100);
    check("tol_no_pulse", 32'(timeout), 32'd0);
    req  = 4'b0000;
    last = 4'b0000;
    cyc("tol_drain");

    // Sole requester finishing every beat alternates grant / idle.
    req  = 4'b0100;
    last = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cyc("sole");
      check("sole_alt", 32'(gnt), (i % 2 == 0) ? 32'b0100 : 32'b0000);
    end
    req  = 4'b0000;
    last = 4'b0000;
    cyc("sole_drain");

    // Asynchronous reset mid-transaction, then restart from pointer 0.
    req = 4'b0010;
    cyc("ar_grant");
    check("ar_owner1", 32'(gnt), 32'b0010);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("ar_async_gnt",   32'(gnt),       32'd0);
    check("ar_async_valid", 32'(gnt_valid), 32'd0);
    cyc("ar_in_reset");
    rst = 1'b0;
    req = 4'b0110;
    cyc("ar_restart");
    check("ar_from_ptr0", 32'(gnt), 32'b0010);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      last = N'($urandom) & N'($urandom);
      rst  = ($urandom_range(79) == 0);
      cyc("rand");
      check("rand.onehot", 32'($onehot0(gnt)), 32'd1);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
